// File: rtl/td4_ctrl.sv
// Instruction sequencer for the td4 4-bit CPU: fetches the ROM byte into the IR, decodes it into
// datapath load/select strobes, owns the carry flag and sequences run / single-step / halt.
//
// state | meaning
// IDLE  | waiting for run or a step request
// FETCH | ir <= instr, no enables
// EXEC  | one-cycle strobes from ir, carry updated at the end of the cycle
// HALT  | self-jump seen, frozen until reset

module td4_ctrl #(
    parameter bit HALT_ON_SELF_JMP = 1'b1,
    parameter bit STEP_EDGE        = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] instr,
    input  logic [3:0] pc,
    input  logic       alu_co,
    output logic [1:0] sel,
    output logic [3:0] im,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_out,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       carry,
    output logic       halted,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    localparam logic [1:0] SRC_A    = 2'b00;
    localparam logic [1:0] SRC_B    = 2'b01;
    localparam logic [1:0] SRC_IN   = 2'b10;
    localparam logic [1:0] SRC_ZERO = 2'b11;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] ir;
    logic       carry_q;
    logic       carry_d;
    logic       step_q;

    logic [3:0] op;
    logic       go;
    logic [1:0] dec_sel;
    logic       dec_ld_a;
    logic       dec_ld_b;
    logic       dec_ld_out;
    logic       dec_take;
    logic       dec_carry;
    logic       self_jmp;

    assign op = ir[7:4];
    assign im = ir[3:0];

    always_comb begin
        if (STEP_EDGE) begin
            go = run | (step & ~step_q);
        end else begin
            go = run | step;
        end
    end

    always_comb begin
        dec_sel    = SRC_A;
        dec_ld_a   = 1'b0;
        dec_ld_b   = 1'b0;
        dec_ld_out = 1'b0;
        dec_take   = 1'b0;
        dec_carry  = 1'b0;
        case (op)
            OP_ADD_A: begin
                dec_sel   = SRC_A;
                dec_ld_a  = 1'b1;
                dec_carry = alu_co;
            end
            OP_MOV_AB: begin
                dec_sel  = SRC_B;
                dec_ld_a = 1'b1;
            end
            OP_IN_A: begin
                dec_sel  = SRC_IN;
                dec_ld_a = 1'b1;
            end
            OP_MOV_AI: begin
                dec_sel  = SRC_ZERO;
                dec_ld_a = 1'b1;
            end
            OP_MOV_BA: begin
                dec_sel  = SRC_A;
                dec_ld_b = 1'b1;
            end
            OP_ADD_B: begin
                dec_sel   = SRC_B;
                dec_ld_b  = 1'b1;
                dec_carry = alu_co;
            end
            OP_IN_B: begin
                dec_sel  = SRC_IN;
                dec_ld_b = 1'b1;
            end
            OP_MOV_BI: begin
                dec_sel  = SRC_ZERO;
                dec_ld_b = 1'b1;
            end
            OP_OUT_B: begin
                dec_sel    = SRC_B;
                dec_ld_out = 1'b1;
            end
            OP_OUT_I: begin
                dec_sel    = SRC_ZERO;
                dec_ld_out = 1'b1;
            end
            OP_JMP: dec_take = 1'b1;
            // JNC looks at the carry left behind by the previous instruction
            OP_JNC: dec_take = ~carry_q;
            default: ;
        endcase
    end

    assign self_jmp = HALT_ON_SELF_JMP && dec_take && (im == pc);

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        sel     = SRC_A;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_out  = 1'b0;
        ld_pc   = 1'b0;
        inc_pc  = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                sel     = dec_sel;
                ld_a    = dec_ld_a;
                ld_b    = dec_ld_b;
                ld_out  = dec_ld_out;
                ld_pc   = dec_take;
                inc_pc  = ~dec_take;
                carry_d = dec_carry;
                if (self_jmp) begin
                    state_d = ST_HALT;
                end else if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_IDLE;
        endcase
        // A reset cycle must not let a half-executed instruction touch the datapath
        if (reset) begin
            sel    = SRC_A;
            ld_a   = 1'b0;
            ld_b   = 1'b0;
            ld_out = 1'b0;
            ld_pc  = 1'b0;
            inc_pc = 1'b0;
            halted = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ir      <= 8'h00;
            carry_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            step_q  <= step;
            if (state_q == ST_FETCH) begin
                ir <= instr;
            end
        end
    end

    assign carry = carry_q;
    assign state = state_q;

endmodule

// File: tb/tb_td4_ctrl.sv
// Bench for td4_ctrl: a small td4 datapath around the controller, compared after every
// instruction against an instruction-level model of the td4 ISA.

module tb_td4_ctrl;

    logic       clk;
    logic       reset;
    logic       run;
    logic       step;
    logic [7:0] instr;
    logic [3:0] pc;
    logic       alu_co;
    logic [1:0] sel;
    logic [3:0] im;
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic       ld_pc;
    logic       inc_pc;
    logic       carry;
    logic       halted;
    logic [1:0] state;

    td4_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .step   (step),
        .instr  (instr),
        .pc     (pc),
        .alu_co (alu_co),
        .sel    (sel),
        .im     (im),
        .ld_a   (ld_a),
        .ld_b   (ld_b),
        .ld_out (ld_out),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .carry  (carry),
        .halted (halted),
        .state  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datapath around the controller
    logic [7:0] rom [16];
    logic [3:0] ra, rb, rout, rpc, in_port, src;
    logic [4:0] sum;

    always_comb begin
        case (sel)
            2'b00:   src = ra;
            2'b01:   src = rb;
            2'b10:   src = in_port;
            default: src = 4'h0;
        endcase
    end
    assign sum    = {1'b0, src} + {1'b0, im};
    assign alu_co = sum[4];
    assign pc     = rpc;
    assign instr  = rom[rpc];

    always @(posedge clk) begin
        if (reset) begin
            ra <= 4'h0; rb <= 4'h0; rout <= 4'h0; rpc <= 4'h0;
        end else begin
            if (ld_a)   ra   <= sum[3:0];
            if (ld_b)   rb   <= sum[3:0];
            if (ld_out) rout <= sum[3:0];
            if (ld_pc)       rpc <= im;
            else if (inc_pc) rpc <= rpc + 4'h1;
        end
    end

    int tests = 0;
    int fails = 0;

    // ISA model state
    logic [3:0] m_a, m_b, m_o, m_pc;
    logic       m_c, m_halt, abort;
    logic       obs_ld_pc, obs_inc_pc;
    logic [3:0] obs_im;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_a = 4'h0; m_b = 4'h0; m_o = 4'h0; m_pc = 4'h0; m_c = 1'b0;
        m_halt = 1'b0; abort = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    // Wait for EXEC, predict the instruction at m_pc, then compare architectural state.
    task automatic exec_one(input bit runmode);
        int         n;
        logic [3:0] op, imm, nxt;
        logic [4:0] s;
        logic       nc, take;
        n = 0;
        while (state !== 2'b10 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("exec_reached", 8'(state), 8'h02);
        if (state !== 2'b10) begin
            abort = 1'b1;
            return;
        end
        obs_ld_pc  = ld_pc;
        obs_inc_pc = inc_pc;
        obs_im     = im;
        op   = rom[m_pc][7:4];
        imm  = rom[m_pc][3:0];
        nxt  = m_pc + 4'h1;
        nc   = 1'b0;
        take = 1'b0;
        case (op)
            4'h0: begin s = {1'b0, m_a} + {1'b0, imm}; m_a = s[3:0]; nc = s[4]; end
            4'h5: begin s = {1'b0, m_b} + {1'b0, imm}; m_b = s[3:0]; nc = s[4]; end
            4'h1: m_a = m_b + imm;
            4'h4: m_b = m_a + imm;
            4'h2: m_a = in_port + imm;
            4'h6: m_b = in_port + imm;
            4'h3: m_a = imm;
            4'h7: m_b = imm;
            4'h9: m_o = m_b + imm;
            4'hB: m_o = imm;
            4'hF: take = 1'b1;
            4'hE: take = ~m_c;
            default: ;
        endcase
        if (take) begin
            m_halt = (imm == m_pc);
            nxt    = imm;
        end
        check("im", 8'(im), 8'(imm));
        check("pc_ctl", 8'({ld_pc, inc_pc}), take ? 8'h02 : 8'h01);
        m_c  = nc;
        m_pc = nxt;
        @(negedge clk);
        check("reg_a", 8'(ra), 8'(m_a));
        check("reg_b", 8'(rb), 8'(m_b));
        check("reg_out", 8'(rout), 8'(m_o));
        check("pc", 8'(rpc), 8'(m_pc));
        check("carry", 8'(carry), 8'(m_c));
        check("halted", 8'(halted), 8'(m_halt));
        check("state_after", 8'(state), m_halt ? 8'h03 : (runmode ? 8'h01 : 8'h00));
    endtask

    initial begin
        int cnt;
        logic [3:0] pc_hold;
        reset = 1'b1; run = 1'b0; step = 1'b0; in_port = 4'h0;
        clear_rom();

        // reset values
        do_reset();
        reset = 1'b1;
        #1;
        check("rst_state", 8'(state), 8'h00);
        check("rst_carry", 8'(carry), 8'h00);
        check("rst_enables", 8'({ld_a, ld_b, ld_out, ld_pc, inc_pc, halted}), 8'h00);
        check("rst_sel_im", 8'({sel, im}), 8'h00);
        reset = 1'b0;

        // MOV A,5 ; ADD A,3 ; OUT B
        clear_rom();
        rom[0] = 8'h35; rom[1] = 8'h03; rom[2] = 8'h90;
        run = 1'b1;
        do_reset();
        exec_one(1'b1);
        check("a_is_5", 8'(ra), 8'h05);
        exec_one(1'b1);
        check("a_is_8", 8'(ra), 8'h08);
        exec_one(1'b1);

        // carry set by wrap, JNC not taken, MOV, JNC taken, self-jump halt
        clear_rom();
        rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE0;
        rom[3] = 8'h35; rom[4] = 8'hE7; rom[7] = 8'hF7;
        do_reset();
        exec_one(1'b1);
        exec_one(1'b1);
        check("wrap_a0", 8'(ra), 8'h00);
        check("wrap_c1", 8'(carry), 8'h01);
        exec_one(1'b1);
        check("jnc_nt_ctl", 8'({obs_ld_pc, obs_inc_pc}), 8'h01);
        exec_one(1'b1);
        exec_one(1'b1);
        check("jnc_t_ctl", 8'({obs_ld_pc, obs_inc_pc, obs_im}), 8'h27);
        exec_one(1'b1);
        check("selfjmp_ldpc", 8'(obs_ld_pc), 8'h01);
        pc_hold = rpc;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            run  = i[0];
            step = i[1];
            @(negedge clk);
            if (state == 2'b10) cnt++;
        end
        check("halt_held", 8'({state, halted}), 8'h07);
        check("halt_no_exec", 8'(cnt), 8'h00);
        check("halt_pc", 8'(rpc), 8'(pc_hold));
        run = 1'b0; step = 1'b0;
        do_reset();
        check("halt_reset_idle", 8'({state, halted}), 8'h00);

        // step held high: exactly one instruction
        clear_rom();
        rom[0] = 8'h35; rom[1] = 8'h36;
        do_reset();
        @(negedge clk);
        step = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (state == 2'b10) cnt++;
        end
        check("step_one_exec", 8'(cnt), 8'h01);
        check("step_idle", 8'(state), 8'h00);
        check("step_a", 8'(ra), 8'h05);
        step = 1'b0;

        // reset during EXEC of ADD A,Im with carry set
        clear_rom();
        rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'h01;
        run = 1'b1;
        do_reset();
        exec_one(1'b1);
        exec_one(1'b1);
        @(negedge clk);
        check("rst_mid_exec", 8'({state, carry}), 8'h05);
        reset = 1'b1;
        #1;
        check("rst_mid_gate", 8'({ld_a, ld_b, ld_out, ld_pc, inc_pc}), 8'h00);
        @(negedge clk);
        check("rst_mid_carry", 8'(carry), 8'h00);
        check("rst_mid_state", 8'(state), 8'h00);
        check("rst_mid_en", 8'({ld_a, ld_b, ld_out, ld_pc, inc_pc, halted}), 8'h00);
        reset = 1'b0; run = 1'b0;

        // random programs, alternating free-run and single-step
        for (int p = 0; p < 14; p++) begin
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            in_port = 4'($urandom);
            run = p[0];
            step = 1'b0;
            do_reset();
            for (int k = 0; k < 25 && !m_halt && !abort; k++) begin
                if (p[0]) begin
                    exec_one(1'b1);
                end else begin
                    step = 1'b1;
                    exec_one(1'b0);
                    step = 1'b0;
                    @(negedge clk);
                end
            end
            run = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
